data_bus_arbiter: RTL and testbench

Round-robin scheduler for the shared 32-bit data bus between the host side and the three accelerator units (FFT, FIR, IIR). Each cycle it decides which unit owns the bus and in which direction:
- **to-unit:** host writes into the unit's input FIFO.
- **from-unit:** the unit's output FIFO drains to the host sink.

It grants bounded bursts, inserts a turnaround cycle before every bus-direction handover, and drives the FIFO push/pop strobes. It sits between the host port and the per-unit FIFOs, and replaces ad-hoc per-unit bus enables.

---
 rtl/data_bus_arbiter.sv | 156 +++++++++++++++
 tb/tb_data_bus_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/data_bus_arbiter.sv
// Round-robin owner/direction scheduler for the shared host <-> accelerator data bus.
// Grants bounded bursts with a turnaround cycle and drives the per-unit FIFO strobes.
module data_bus_arbiter #(
   parameter int unsigned BURST = 4,
   parameter int unsigned CNT_W = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] unit_en,
   input  logic [2:0] to_req,
   input  logic [2:0] to_full,
   input  logic [2:0] from_empty,
   input  logic [2:0] from_full,
   input  logic       sink_ready,
   output logic [2:0] grant,
   output logic       dir,
   output logic [2:0] to_push,
   output logic [2:0] from_pop,
   output logic       src_ack,
   output logic       sink_valid,
   output logic       busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      XFER  = 2'd2
   } state_e;

   state_e             state_q;
   logic [2:0]         grant_q;
   logic               dir_q;
   logic [1:0]         ptr_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [CNT_W-1:0]   cnt_d;

   logic [2:0]         to_ok;
   logic [2:0]         from_ok;
   logic [2:0]         elig;
   logic               pick_found;
   logic [1:0]         pick_idx;
   logic               dir_sel;
   logic [1:0]         gidx;
   logic               strobe;
   logic               last_beat;

   function automatic logic [1:0] inc3(input logic [1:0] v);
      return (v == 2'd2) ? 2'd0 : v + 2'd1;
   endfunction

   always_comb begin
      to_ok   = unit_en & to_req & ~to_full;
      from_ok = unit_en & ~from_empty & {3{sink_ready}};
      elig    = to_ok | from_ok;
   end

   // Scan starts one past the last owner so every eligible unit gets its turn.
   always_comb begin
      logic [1:0] cand;
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = inc3(ptr_q);
      for (int unsigned k = 0; k < 3; k++) begin
         if (!pick_found && elig[cand]) begin
            pick_found = 1'b1;
            pick_idx   = cand;
         end
         cand = inc3(cand);
      end
   end

   // Urgent drain wins the direction choice only inside the chosen unit.
   always_comb begin
      dir_sel = 1'b0;
      if (from_full[pick_idx] && from_ok[pick_idx]) begin
         dir_sel = 1'b0;
      end else if (to_ok[pick_idx]) begin
         dir_sel = 1'b1;
      end
   end

   always_comb begin
      gidx = 2'd0;
      if (grant_q[1]) begin
         gidx = 2'd1;
      end else if (grant_q[2]) begin
         gidx = 2'd2;
      end
   end

   always_comb begin
      to_push  = '0;
      from_pop = '0;
      if (state_q == XFER) begin
         if (dir_q) begin
            to_push = grant_q & to_ok;
         end else begin
            from_pop = grant_q & from_ok;
         end
      end
      strobe    = |(to_push | from_pop);
      cnt_d     = cnt_q + CNT_W'(1);
      last_beat = (cnt_d == CNT_W'(BURST));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         grant_q <= '0;
         dir_q   <= 1'b0;
         ptr_q   <= 2'd2;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (pick_found) begin
                  grant_q <= 3'b001 << pick_idx;
                  dir_q   <= dir_sel;
                  cnt_q   <= '0;
                  state_q <= GRANT;
               end
            end
            GRANT: begin
               state_q <= XFER;
            end
            XFER: begin
               if (strobe) begin
                  cnt_q <= cnt_d;
               end
               // A stalled cycle or the final counted beat both close the burst.
               if (!strobe || last_beat) begin
                  ptr_q   <= gidx;
                  grant_q <= '0;
                  state_q <= IDLE;
               end
            end
            default: begin
               grant_q <= '0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign grant      = grant_q;
   assign dir        = dir_q;
   assign src_ack    = |to_push;
   assign sink_valid = |from_pop;
   assign busy       = (state_q != IDLE);

   a_grant_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant_q));
   a_strobe_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(to_push | from_pop));
   a_strobe_in_xfer: assert property (@(posedge clk) disable iff (!rst_n)
      (|(to_push | from_pop)) |-> (state_q == XFER));

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Directed bench for data_bus_arbiter: reset, bursts, rotation, stalls, direction choice, disable.
module tb_data_bus_arbiter;

   logic       clk;
   logic       rst_n;
   logic [2:0] unit_en;
   logic [2:0] to_req;
   logic [2:0] to_full;
   logic [2:0] from_empty;
   logic [2:0] from_full;
   logic       sink_ready;
   logic [2:0] grant;
   logic       dir;
   logic [2:0] to_push;
   logic [2:0] from_pop;
   logic       src_ack;
   logic       sink_valid;
   logic       busy;

   int checks;
   int failures;

   data_bus_arbiter #(.BURST(4), .CNT_W(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .unit_en   (unit_en),
      .to_req    (to_req),
      .to_full   (to_full),
      .from_empty(from_empty),
      .from_full (from_full),
      .sink_ready(sink_ready),
      .grant     (grant),
      .dir       (dir),
      .to_push   (to_push),
      .from_pop  (from_pop),
      .src_ack   (src_ack),
      .sink_valid(sink_valid),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      unit_en    = 3'b000;
      to_req     = 3'b000;
      to_full    = 3'b000;
      from_empty = 3'b111;
      from_full  = 3'b000;
      sink_ready = 1'b0;
      rst_n      = 1'b0;
      cyc();
      cyc();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (grant !== 3'b000) begin failures++; $display("FAIL reset_grant got=%b exp=000", grant); end
      checks++; if (dir !== 1'b0) begin failures++; $display("FAIL reset_dir got=%b exp=0", dir); end
      checks++; if ({to_push, from_pop, src_ack, sink_valid, busy} !== 9'b0)
         begin failures++; $display("FAIL reset_strobes got=%b exp=0", {to_push, from_pop, src_ack, sink_valid, busy}); end
      unit_en = 3'b111;
      to_req  = 3'b010;
      cyc();
      checks++; if (grant !== 3'b010) begin failures++; $display("FAIL rst_pre_grant got=%b exp=010", grant); end
      cyc();
      checks++; if (to_push !== 3'b010) begin failures++; $display("FAIL rst_pre_push got=%b exp=010", to_push); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (grant !== 3'b000) begin failures++; $display("FAIL async_grant got=%b exp=000", grant); end
      checks++; if ({to_push, src_ack, busy} !== 5'b0) begin failures++; $display("FAIL async_strobes got=%b exp=0", {to_push, src_ack, busy}); end
      cyc();
      rst_n  = 1'b1;
      to_req = 3'b011;
      cyc();
      checks++; if (grant !== 3'b001) begin failures++; $display("FAIL rst_first_grant got=%b exp=001", grant); end
   endtask

   task automatic test_single_burst();
      do_reset();
      unit_en = 3'b001;
      to_req  = 3'b001;
      cyc();
      checks++; if ({grant, dir} !== 4'b0011) begin failures++; $display("FAIL single_grant got=%b exp=0011", {grant, dir}); end
      checks++; if ({to_push, busy} !== 4'b0001) begin failures++; $display("FAIL single_turnaround got=%b exp=0001", {to_push, busy}); end
      for (int i = 0; i < 4; i++) begin
         cyc();
         checks++; if ({to_push, src_ack, sink_valid} !== 5'b00110)
            begin failures++; $display("FAIL single_beat%0d got=%b exp=00110", i, {to_push, src_ack, sink_valid}); end
      end
      cyc();
      checks++; if ({grant, to_push, busy} !== 7'b0) begin failures++; $display("FAIL single_end got=%b exp=0", {grant, to_push, busy}); end
      to_req = 3'b000;
   endtask

   task automatic test_round_robin();
      logic [2:0] seq [4];
      seq[0] = 3'b001; seq[1] = 3'b010; seq[2] = 3'b100; seq[3] = 3'b001;
      do_reset();
      unit_en    = 3'b111;
      to_req     = 3'b111;
      from_empty = 3'b000;
      sink_ready = 1'b1;
      for (int g = 0; g < 4; g++) begin
         cyc();
         checks++; if ({grant, dir} !== {seq[g], 1'b1}) begin failures++; $display("FAIL rr_grant%0d got=%b exp=%b1", g, {grant, dir}, seq[g]); end
         for (int b = 0; b < 4; b++) begin
            cyc();
            checks++; if ({to_push, from_pop} !== {seq[g], 3'b000})
               begin failures++; $display("FAIL rr_beat%0d_%0d got=%b exp=%b000", g, b, {to_push, from_pop}, seq[g]); end
         end
         cyc();
         checks++; if (grant !== 3'b000) begin failures++; $display("FAIL rr_idle%0d got=%b exp=000", g, grant); end
      end
   endtask

   task automatic test_stall();
      do_reset();
      unit_en    = 3'b111;
      from_empty = 3'b101;
      sink_ready = 1'b1;
      cyc();
      checks++; if ({grant, dir} !== 4'b0100) begin failures++; $display("FAIL stall_grant got=%b exp=0100", {grant, dir}); end
      for (int b = 0; b < 2; b++) begin
         cyc();
         checks++; if ({from_pop, sink_valid} !== 4'b0101) begin failures++; $display("FAIL stall_pop%0d got=%b exp=0101", b, {from_pop, sink_valid}); end
      end
      sink_ready = 1'b0;
      #1;
      checks++; if ({from_pop, sink_valid} !== 4'b0000) begin failures++; $display("FAIL stall_nopop got=%b exp=0000", {from_pop, sink_valid}); end
      cyc();
      checks++; if ({grant, busy} !== 4'b0000) begin failures++; $display("FAIL stall_end got=%b exp=0000", {grant, busy}); end
      sink_ready = 1'b1;
      to_req     = 3'b101;
      cyc();
      checks++; if ({grant, dir} !== 4'b1001) begin failures++; $display("FAIL stall_next got=%b exp=1001", {grant, dir}); end
   endtask

   task automatic test_dir_priority();
      do_reset();
      unit_en    = 3'b111;
      to_req     = 3'b100;
      from_empty = 3'b011;
      from_full  = 3'b100;
      sink_ready = 1'b1;
      cyc();
      checks++; if ({grant, dir} !== 4'b1000) begin failures++; $display("FAIL prio_grant got=%b exp=1000", {grant, dir}); end
      for (int b = 0; b < 4; b++) begin
         cyc();
         checks++; if ({from_pop, to_push} !== 6'b100000) begin failures++; $display("FAIL prio_drain%0d got=%b exp=100000", b, {from_pop, to_push}); end
      end
      cyc();
      checks++; if (grant !== 3'b000) begin failures++; $display("FAIL prio_idle got=%b exp=000", grant); end
      from_empty = 3'b111;
      from_full  = 3'b000;
      cyc();
      checks++; if ({grant, dir} !== 4'b1001) begin failures++; $display("FAIL prio_to_grant got=%b exp=1001", {grant, dir}); end
      cyc();
      checks++; if (to_push !== 3'b100) begin failures++; $display("FAIL prio_push got=%b exp=100", to_push); end
   endtask

   task automatic test_disable();
      do_reset();
      unit_en = 3'b111;
      to_req  = 3'b001;
      cyc();
      checks++; if ({grant, dir} !== 4'b0011) begin failures++; $display("FAIL dis_grant got=%b exp=0011", {grant, dir}); end
      cyc();
      checks++; if (to_push !== 3'b001) begin failures++; $display("FAIL dis_beat got=%b exp=001", to_push); end
      unit_en = 3'b110;
      #1;
      checks++; if ({to_push, src_ack} !== 4'b0000) begin failures++; $display("FAIL dis_nopush got=%b exp=0000", {to_push, src_ack}); end
      cyc();
      checks++; if ({grant, busy} !== 4'b0000) begin failures++; $display("FAIL dis_end got=%b exp=0000", {grant, busy}); end
      for (int i = 0; i < 3; i++) begin
         cyc();
         checks++; if (grant !== 3'b000) begin failures++; $display("FAIL dis_hold%0d got=%b exp=000", i, grant); end
      end
      to_req = 3'b011;
      cyc();
      checks++; if (grant !== 3'b010) begin failures++; $display("FAIL dis_other got=%b exp=010", grant); end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_single_burst();
      test_round_robin();
      test_stall();
      test_dir_priority();
      test_disable();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
